// File: rtl/debug_master_pkg.sv
// Shared constants for the debug master: opcodes, CPU control register map,
// CPU state codes, step timeout and FSM state encodings.
package debug_master_pkg;

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_READ  = 2'd1;
   localparam logic [1:0] OP_STEP  = 2'd2;
   localparam logic [1:0] OP_HALT  = 2'd3;

   localparam logic [7:0] CTRL_CPU_STATE = 8'hF0;
   localparam logic [3:0] STATE_FETCH    = 4'h1;
   localparam logic [3:0] STATE_NEXT     = 4'h4;
   // No transition leaves STATE_HALT in the CPU control FSM, so the CPU parks there.
   localparam logic [3:0] STATE_HALT     = 4'hF;

   localparam logic [7:0] STEP_TIMEOUT = 8'd255;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_BUS_WR    = 3'd1;
   localparam logic [2:0] S_BUS_RD    = 3'd2;
   localparam logic [2:0] S_STEP_GO   = 3'd3;
   localparam logic [2:0] S_STEP_WAIT = 3'd4;
   localparam logic [2:0] S_RESP      = 3'd5;

endpackage

// File: rtl/debug_master.sv
// Host-driven debug master: turns WRITE/READ/STEP/HALT commands into single
// system-bus cycles against the CPU and returns one response per command.
module debug_master
   import debug_master_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic [7:0] bus_addr,
   output logic       bus_read,
   output logic       bus_write,
   inout  wire  [7:0] bus_data,
   input  logic [3:0] cpu_state,
   output logic       busy,
   output logic [2:0] dbg_state
);

   // Handshakes: a command transfers on a clock edge where cmd_valid && cmd_ready;
   // a response transfers on an edge where rsp_valid && rsp_ready. The side that
   // raised valid holds it and its payload unchanged until that edge.

   logic [2:0] state_q;
   logic [7:0] addr_q;
   logic [7:0] data_q;
   logic [7:0] rsp_q;
   logic [7:0] cnt_q;
   logic [7:0] wdata;
   logic       cpu_next;

   assign cpu_next  = (cpu_state == STATE_NEXT);
   assign cmd_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign busy      = (state_q != S_IDLE);
   assign rsp_data  = rsp_q;
   assign dbg_state = state_q;
   assign bus_data  = bus_write ? wdata : 8'hzz;

   always_comb begin
      bus_write = 1'b0;
      bus_read  = 1'b0;
      bus_addr  = 8'h00;
      wdata     = 8'h00;
      case (state_q)
         S_BUS_WR: begin
            bus_write = 1'b1;
            bus_addr  = addr_q;
            wdata     = data_q;
         end
         S_BUS_RD: begin
            bus_read = 1'b1;
            bus_addr = addr_q;
         end
         S_STEP_GO: begin
            bus_write = 1'b1;
            bus_addr  = CTRL_CPU_STATE;
            wdata     = {4'h0, STATE_FETCH};
         end
         S_STEP_WAIT: begin
            // Halt lands in the same cycle NEXT is seen, before the CPU can refetch.
            if (cpu_next) begin
               bus_write = 1'b1;
               bus_addr  = CTRL_CPU_STATE;
               wdata     = {4'h0, STATE_HALT};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         addr_q  <= 8'h00;
         data_q  <= 8'h00;
         rsp_q   <= 8'h00;
         cnt_q   <= 8'h00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cmd_valid) begin
                  addr_q <= cmd_addr;
                  data_q <= cmd_data;
                  case (cmd_op)
                     OP_WRITE: state_q <= S_BUS_WR;
                     OP_READ:  state_q <= S_BUS_RD;
                     OP_STEP:  state_q <= S_STEP_GO;
                     default: begin
                        addr_q  <= CTRL_CPU_STATE;
                        data_q  <= {4'h0, STATE_HALT};
                        state_q <= S_BUS_WR;
                     end
                  endcase
               end
            end
            S_BUS_WR: begin
               rsp_q   <= data_q;
               state_q <= S_RESP;
            end
            S_BUS_RD: begin
               rsp_q   <= bus_data;
               state_q <= S_RESP;
            end
            S_STEP_GO: begin
               cnt_q   <= 8'h00;
               state_q <= S_STEP_WAIT;
            end
            S_STEP_WAIT: begin
               if (cpu_next) begin
                  rsp_q   <= 8'h00;
                  state_q <= S_RESP;
               end else if (cnt_q == STEP_TIMEOUT) begin
                  rsp_q   <= 8'hFF;
                  state_q <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            S_RESP: begin
               if (rsp_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/debug_master.md
DEBUG_MASTER -- requirements
Module: debug_master

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on posedge clk.
REQ-002 SHALL have reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have cmd_valid, input, 1, host command present.
REQ-004 SHALL have cmd_ready, output, 1, command accepted when high with cmd_valid.
REQ-005 SHALL have cmd_op, input, 2; 0 = WRITE, 1 = READ, 2 = STEP, 3 = HALT.
REQ-006 SHALL have cmd_addr, input, 8, bus address for WRITE/READ.
REQ-007 SHALL have cmd_data, input, 8, write data for WRITE.
REQ-008 SHALL have rsp_valid, output, 1, response present.
REQ-009 SHALL have rsp_ready, input, 1, host consumes response.
REQ-010 SHALL have rsp_data, output, 8, response payload.
REQ-011 SHALL have bus_addr, output, 8, system bus address.
REQ-012 SHALL have bus_read, output, 1, bus read strobe.
REQ-013 SHALL have bus_write, output, 1, bus write strobe.
REQ-014 SHALL have bus_data, inout, 8; driven only while bus_write=1, else high-Z.
REQ-015 SHALL have cpu_state, input, 4, current CPU control state.
REQ-016 SHALL have busy, output, 1, high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states: IDLE, BUS_WR, BUS_RD, STEP_GO, STEP_WAIT, RESP.
REQ-018 SHALL assert cmd_ready only in IDLE; acceptance occurs on an edge with cmd_valid=1 and cmd_ready=1, latching op, addr and data.
REQ-019 SHALL latch a WRITE and go to BUS_WR: one cycle with bus_write=1, bus_addr=addr, bus_data=data, then RESP with rsp_data=data.
REQ-020 SHALL latch a READ and go to BUS_RD: one cycle with bus_read=1, bus_addr=addr; it captures bus_data at the closing edge into rsp_data, then goes to RESP.
REQ-021 SHALL handle HALT as a WRITE of STATE_HALT to CTRL_CPU_STATE; rsp_data=STATE_HALT.
REQ-022 SHALL handle STEP in STEP_GO with a one-cycle write of STATE_FETCH to CTRL_CPU_STATE, then go to STEP_WAIT with the timeout counter cleared.
REQ-023 SHALL, in STEP_WAIT, drive the bus write of STATE_HALT to CTRL_CPU_STATE combinationally in the same cycle cpu_state==STATE_NEXT, so no further fetch occurs; it then goes to RESP with rsp_data=8'h00.
REQ-024 SHALL increment an 8-bit counter each STEP_WAIT cycle; on reaching 255 without STATE_NEXT it goes to RESP with rsp_data=8'hFF, and the bus stays idle.
REQ-025 SHALL hold rsp_valid=1 and rsp_data stable in RESP until rsp_ready=1, then return to IDLE; back-to-back commands therefore have minimum 3-cycle spacing.
REQ-026 SHALL never assert bus_read and bus_write together; bus_addr=0 when neither strobe is high.
REQ-027 SHALL give latency of 1 bus cycle plus 1 cycle to rsp_valid for WRITE, READ and HALT.
REQ-028 SHALL accept cmd_valid pulses while busy without effect; the host holds cmd_valid until cmd_ready.

Reset
REQ-029 SHALL, on reset_n low, immediately enter IDLE with cmd_ready=1, rsp_valid=0, rsp_data=0, bus strobes=0, bus_data high-Z, busy=0 and counter=0.
REQ-030 SHALL abort any transaction if reset occurs mid-operation, including STEP_WAIT; no response is produced and the CPU state is left unchanged.

Structure
REQ-031 SHALL take CTRL_CPU_STATE, STATE_FETCH, STATE_NEXT and the new STATE_HALT=4'hF from parameters.vh; STATE_HALT is unused by the control FSM, so the CPU holds there.
REQ-032 SHALL keep command opcode encodings and the timeout limit (255) as constants in parameters.vh.
REQ-033 SHALL be a single module with no sub-modules.

Verification
REQ-034 SHALL verify WRITE addr=8'h10, data=8'hA5: one cycle bus_write=1, bus_addr=8'h10, bus_data=8'hA5; then rsp_data=8'hA5.
REQ-035 SHALL verify READ addr=8'h20 with bus model returning 8'h3C: one cycle bus_read=1; rsp_data=8'h3C.
REQ-036 SHALL verify STEP against the control FSM model, CPU halted at 4'hF: sequence FETCH..NEXT, halt written in the NEXT cycle, cpu_state=4'hF next cycle, rsp_data=8'h00, exactly one fetch.
REQ-037 SHALL verify STEP with cpu_state stuck at 4'hF: rsp_data=8'hFF after 256 STEP_WAIT cycles, with no bus activity during the wait.
REQ-038 SHALL verify that holding rsp_ready=0 for 10 cycles keeps rsp_valid and rsp_data stable and cmd_ready=0.
REQ-039 SHALL verify that reset_n low in STEP_WAIT at cycle 5 gives outputs at reset values asynchronously and no response.
